// File: rtl/haar_pkg.sv
// Shared types and constants for the Haar front-end.
// Holds the line-buffer reader FSM encoding and slice helpers.
package haar_pkg;

    localparam int BYTE_WIDTH        = 8;
    localparam int BYTE_DOUBLE_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_GAP,
        ST_DONE
    } rd_state_t;

    function automatic int col_slice_lo(
        input int k,
        input int w
    );
        return k * w;
    endfunction

endpackage

// File: rtl/column_pipe_reg.sv
// Single-entry valid/ready register.
// A load always wins; otherwise a handshake empties the entry.
module column_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_window_reader.sv
// Drains the row FIFOs in lockstep and streams tagged pixel columns.
// Frame geometry, row gaps and end-of-frame are sequenced here.
module fifo_window_reader #(
    parameter int FIFO_DATA_WIDTH      = 8,
    parameter int FIFO_COMPONENT_COUNT = 6,
    parameter int FRAME_WIDTH          = 10,
    parameter int FRAME_HEIGHT         = 10,
    parameter int LINE_GAP             = 2,
    parameter int BYTE_DOUBLE_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_start,
    input  logic [FIFO_COMPONENT_COUNT-1:0] i_fifo_empty,
    input  logic [FIFO_COMPONENT_COUNT*FIFO_DATA_WIDTH-1:0] i_fifo_rdata,
    output logic [FIFO_COMPONENT_COUNT-1:0] o_fifo_rd,
    output logic [FIFO_COMPONENT_COUNT*FIFO_DATA_WIDTH-1:0] o_column_data,
    output logic                    o_column_valid,
    input  logic                    i_column_ready,
    output logic [BYTE_DOUBLE_WIDTH-1:0] o_xcoord,
    output logic [BYTE_DOUBLE_WIDTH-1:0] o_ycoord,
    output logic                    o_busy,
    output logic                    o_frame_done
);

    import haar_pkg::*;

    localparam int DW  = FIFO_DATA_WIDTH;
    localparam int CNT = FIFO_COMPONENT_COUNT;
    localparam int BDW = BYTE_DOUBLE_WIDTH;
    localparam int CW  = CNT * DW;
    localparam int PW  = CW + 2 * BDW;

    localparam logic [BDW-1:0] X_LAST = BDW'(FRAME_WIDTH - 1);
    localparam logic [BDW-1:0] Y_LAST = BDW'(FRAME_HEIGHT - 1);
    localparam logic [BDW-1:0] GAP_LAST =
        (LINE_GAP > 0) ? BDW'(LINE_GAP - 1) : '0;
    localparam logic [BDW-1:0] ONE = BDW'(1);

    if (FRAME_WIDTH < 1 || FRAME_WIDTH >= 65536 ||
        FRAME_HEIGHT < 1 || FRAME_HEIGHT >= 65536) begin : g_geom_chk
        $error("fifo_window_reader: frame geometry out of range");
    end

    rd_state_t      state;
    logic [BDW-1:0] x_cnt;
    logic [BDW-1:0] y_cnt;
    logic [BDW-1:0] gap_cnt;
    logic           pop;
    logic           col_valid;
    logic           drained;
    logic [PW-1:0]  pipe_d;
    logic [PW-1:0]  pipe_q;

    assign drained = !col_valid || i_column_ready;
    assign pop = (state == ST_STREAM) && !(|i_fifo_empty) && drained;
    assign o_fifo_rd = {CNT{pop}};

    for (genvar k = 0; k < CNT; k++) begin : g_slice
        assign pipe_d[col_slice_lo(k, DW) +: DW] =
            i_fifo_rdata[col_slice_lo(k, DW) +: DW];
    end
    assign pipe_d[CW +: BDW]       = x_cnt;
    assign pipe_d[CW + BDW +: BDW] = y_cnt;

    column_pipe_reg #(
        .WIDTH (PW)
    ) u_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (pop),
        .i_data  (pipe_d),
        .i_ready (i_column_ready),
        .o_data  (pipe_q),
        .o_valid (col_valid)
    );

    assign o_column_valid = col_valid;
    assign o_column_data  = pipe_q[CW-1:0];
    assign o_xcoord       = pipe_q[CW +: BDW];
    assign o_ycoord       = pipe_q[CW + BDW +: BDW];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            x_cnt        <= '0;
            y_cnt        <= '0;
            gap_cnt      <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        x_cnt  <= '0;
                        y_cnt  <= '0;
                        o_busy <= 1'b1;
                        state  <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (pop && x_cnt == X_LAST) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + ONE;
                        // last row drains through DONE, others may rest
                        if (y_cnt == Y_LAST) begin
                            state <= ST_DONE;
                        end else if (LINE_GAP > 0) begin
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end
                    end else if (pop) begin
                        x_cnt <= x_cnt + ONE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_STREAM;
                    end else begin
                        gap_cnt <= gap_cnt + ONE;
                    end
                end
                ST_DONE: begin
                    if (drained) begin
                        o_frame_done <= 1'b1;
                        o_busy       <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_window_reader.sv
// Scoreboard bench for fifo_window_reader.
// Two instances: one with a 2-cycle row gap, one with no gap.
module tb_fifo_window_reader;

    localparam int DW  = 8;
    localparam int CNT = 6;
    localparam int FW  = 10;
    localparam int FH  = 10;
    localparam int CW  = CNT * DW;
    localparam int NCOL = FW * FH;

    typedef struct packed {
        logic [15:0]   y;
        logic [15:0]   x;
        logic [CW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;
    int phase = 0;

    task automatic check(
        input string       name,
        input logic [63:0] act,
        input logic [63:0] exp
    );
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] head(input int p);
        logic [CW-1:0] r;
        for (int k = 0; k < CNT; k++) begin
            r[k*DW +: DW] = 8'(p * 7 + k * 37 + 3);
        end
        return r;
    endfunction

    // instance A: LINE_GAP = 2
    logic           a_start = 1'b0;
    logic           a_ready = 1'b1;
    logic [CNT-1:0] a_empty = '0;
    logic [CW-1:0]  a_rdata;
    logic [CNT-1:0] a_rd;
    logic [CW-1:0]  a_data;
    logic           a_valid;
    logic [15:0]    a_x;
    logic [15:0]    a_y;
    logic           a_busy;
    logic           a_done;

    // instance B: LINE_GAP = 0
    logic           b_start = 1'b0;
    logic           b_ready = 1'b1;
    logic [CNT-1:0] b_empty = '0;
    logic [CW-1:0]  b_rdata;
    logic [CNT-1:0] b_rd;
    logic [CW-1:0]  b_data;
    logic           b_valid;
    logic [15:0]    b_x;
    logic [15:0]    b_y;
    logic           b_busy;
    logic           b_done;

    fifo_window_reader #(
        .FIFO_DATA_WIDTH      (DW),
        .FIFO_COMPONENT_COUNT (CNT),
        .FRAME_WIDTH          (FW),
        .FRAME_HEIGHT         (FH),
        .LINE_GAP             (2),
        .BYTE_DOUBLE_WIDTH    (16)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_start        (a_start),
        .i_fifo_empty   (a_empty),
        .i_fifo_rdata   (a_rdata),
        .o_fifo_rd      (a_rd),
        .o_column_data  (a_data),
        .o_column_valid (a_valid),
        .i_column_ready (a_ready),
        .o_xcoord       (a_x),
        .o_ycoord       (a_y),
        .o_busy         (a_busy),
        .o_frame_done   (a_done)
    );

    fifo_window_reader #(
        .FIFO_DATA_WIDTH      (DW),
        .FIFO_COMPONENT_COUNT (CNT),
        .FRAME_WIDTH          (FW),
        .FRAME_HEIGHT         (FH),
        .LINE_GAP             (0),
        .BYTE_DOUBLE_WIDTH    (16)
    ) u_dut0 (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_start        (b_start),
        .i_fifo_empty   (b_empty),
        .i_fifo_rdata   (b_rdata),
        .o_fifo_rd      (b_rd),
        .o_column_data  (b_data),
        .o_column_valid (b_valid),
        .i_column_ready (b_ready),
        .o_xcoord       (b_x),
        .o_ycoord       (b_y),
        .o_busy         (b_busy),
        .o_frame_done   (b_done)
    );

    // show-ahead FIFO models: head advances on each pop
    int ptr_a = 0;
    int ptr_b = 1000;
    assign a_rdata = head(ptr_a);
    assign b_rdata = head(ptr_b);
    always @(posedge clk) if (a_rd[0]) ptr_a <= ptr_a + 1;
    always @(posedge clk) if (b_rd[0]) ptr_b <= ptr_b + 1;

    exp_t qa[$];
    exp_t qb[$];
    int   base_a = 0;
    int   base_b = 0;

    // monitor A
    logic          a_hold = 1'b0;
    logic [CW-1:0] a_hd;
    logic [15:0]   a_hx;
    logic [15:0]   a_hy;
    int            a_last_pop = 0;
    int            a_last_hs = 0;

    always @(negedge clk) begin
        exp_t e;
        int   idx;
        if (!reset_n) begin
            a_hold = 1'b0;
        end else begin
            if (|a_empty || (a_valid && !a_ready)) begin
                check("a_rd_blocked", 64'(a_rd), 64'd0);
            end else if (|a_rd) begin
                check("a_rd_lockstep", 64'(a_rd), 64'h3f);
            end
            if (a_hold && a_valid) begin
                check("a_hold_data", 64'(a_data), 64'(a_hd));
                check("a_hold_x", 64'(a_x), 64'(a_hx));
                check("a_hold_y", 64'(a_y), 64'(a_hy));
            end
            a_hold = a_valid && !a_ready;
            a_hd = a_data;
            a_hx = a_x;
            a_hy = a_y;
            if (a_rd[0]) begin
                idx = ptr_a - base_a;
                if (phase == 1 && idx > 0 && idx % FW == 0) begin
                    check("a_row_gap", 64'(cyc - a_last_pop), 64'd3);
                end
                a_last_pop = cyc;
            end
            if (a_valid && a_ready) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_col", 64'd1, 64'd0);
                end else begin
                    e = qa.pop_front();
                    check("a_col_data", 64'(a_data), 64'(e.d));
                    check("a_col_x", 64'(a_x), 64'(e.x));
                    check("a_col_y", 64'(a_y), 64'(e.y));
                    if (qa.size() == 0) a_last_hs = cyc;
                end
            end
            if (a_done) begin
                check("a_done_latency", 64'(cyc), 64'(a_last_hs + 1));
            end
        end
    end

    // monitor B
    int b_pops = 0;

    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (b_rd[0]) begin
                b_pops++;
                check("b_pop_when_full", 64'(b_valid && !b_ready), 64'd0);
            end
            if (b_valid && b_ready) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_col", 64'd1, 64'd0);
                end else begin
                    e = qb.pop_front();
                    check("b_col_data", 64'(b_data), 64'(e.d));
                    check("b_col_x", 64'(b_x), 64'(e.x));
                    check("b_col_y", 64'(b_y), 64'(e.y));
                end
            end
            if (b_done) begin
                check("b_total_pops", 64'(b_pops), 64'(NCOL));
                check("b_queue_left", 64'(qb.size()), 64'd0);
            end
        end
    end

    task automatic push_frame(input int base, input bit to_a);
        exp_t e;
        for (int n = 0; n < NCOL; n++) begin
            e.x = 16'(n % FW);
            e.y = 16'(n / FW);
            e.d = head(base + n);
            if (to_a) qa.push_back(e);
            else qb.push_back(e);
        end
    endtask

    task automatic start_a();
        base_a = ptr_a;
        push_frame(base_a, 1'b1);
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
    endtask

    task automatic wait_done_a(input string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!a_done && t < 800);
        check(name, 64'(t >= 800), 64'd0);
        check("a_queue_left", 64'(qa.size()), 64'd0);
        @(posedge clk); #1;
        check("a_idle_busy", 64'(a_busy), 64'd0);
    endtask

    task automatic wait_pops_a(input int n);
        int t = 0;
        while (ptr_a - base_a < n && t < 800) begin
            @(posedge clk); #1;
            t++;
        end
        check("a_pop_wait_timeout", 64'(t >= 800), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(a_valid), 64'd0);
        check({tag, "_data"}, 64'(a_data), 64'd0);
        check({tag, "_x"}, 64'(a_x), 64'd0);
        check({tag, "_y"}, 64'(a_y), 64'd0);
        check({tag, "_busy"}, 64'(a_busy), 64'd0);
        check({tag, "_done"}, 64'(a_done), 64'd0);
        check({tag, "_rd"}, 64'(a_rd), 64'd0);
    endtask

    initial begin
        int p0;
        int t;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        check("rst_b_valid", 64'(b_valid), 64'd0);
        reset_n = 1'b1;

        // full frame, ready high, FIFOs full
        phase = 1;
        start_a();
        @(posedge clk); #1;
        check("a_stream_busy", 64'(a_busy), 64'd1);
        wait_done_a("a_frame1_timeout");

        // FIFO 3 empty mid-row, then downstream stall
        phase = 2;
        start_a();
        wait_pops_a(25);
        a_empty[3] = 1'b1;
        p0 = ptr_a;
        repeat (5) @(posedge clk);
        #1 a_empty = '0;
        check("a_empty_no_pop", 64'(ptr_a), 64'(p0));
        wait_pops_a(55);
        check("a_valid_at_stall", 64'(a_valid), 64'd1);
        a_ready = 1'b0;
        p0 = ptr_a;
        repeat (4) @(posedge clk);
        #1;
        check("a_stall_no_pop", 64'(ptr_a), 64'(p0));
        a_ready = 1'b1;
        wait_done_a("a_frame2_timeout");

        // start ignored mid-frame, then reset at column (4,3)
        phase = 3;
        start_a();
        wait_pops_a(5);
        a_start = 1'b1;
        repeat (2) @(posedge clk);
        #1 a_start = 1'b0;
        t = 0;
        seen = 1'b0;
        while (!seen && t < 400) begin
            @(negedge clk);
            t++;
            seen = a_valid && a_x == 16'd4 && a_y == 16'd3;
        end
        check("a_col43_timeout", 64'(seen), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        qa.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        start_a();
        wait_done_a("a_restart_timeout");

        // no-gap instance, ready toggling
        phase = 4;
        base_b = ptr_b;
        push_frame(base_b, 1'b0);
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        t = 0;
        seen = 1'b0;
        while (!seen && t < 1000) begin
            @(posedge clk);
            #1 b_ready = ~b_ready;
            t++;
            @(negedge clk);
            seen = b_done;
        end
        check("b_frame_timeout", 64'(seen), 64'd1);
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_window_reader.md
# fifo_window_reader

Read side of the line-buffer bank in `ram_memory`. The block drains `FIFO_COMPONENT_COUNT` show-ahead row FIFOs in lockstep and emits one vertical pixel column per transfer, tagged with frame coordinates. Output is a valid/ready stream feeding the Haar window/integral stage. Frame geometry is counted internally and the block signals end of frame.

## Interface
- `FIFO_DATA_WIDTH`, 8: pixel width in bits.
- `FIFO_COMPONENT_COUNT`, 6: number of row FIFOs; equals column height.
- `FRAME_WIDTH`, 10: columns per row.
- `FRAME_HEIGHT`, 10: rows per frame; each row is one column pass.
- `LINE_GAP`, 2: idle cycles inserted between rows; 0 is legal.
- `BYTE_DOUBLE_WIDTH`, 16: coordinate width.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  starts a frame; sampled only in IDLE.
- `i_fifo_empty`  in  COUNT  per-FIFO empty flag.
- `i_fifo_rdata`  in  COUNT*DATA  show-ahead head words; FIFO k occupies slice [k*DATA +: DATA].
- `o_fifo_rd`  out  COUNT  pop strobes; all bits are always equal.
- `o_column_data`  out  COUNT*DATA  registered column, same slice layout as `i_fifo_rdata`.
- `o_column_valid`  out  1  column register is full.
- `i_column_ready`  in  1  downstream accepts the column.
- `o_xcoord`, `o_ycoord`  out  16 each  coordinates of the column in the register.
- `o_busy`  out  1  high in every state except IDLE.
- `o_frame_done`  out  1  one-cycle pulse at frame end.

## Operation
- The FSM has four states: IDLE, STREAM, GAP, DONE.
- IDLE to STREAM: `i_start`=1. On this transition, clear the x and y counters.
- The pop condition is `pop` = STREAM & all FIFOs non-empty & (!`o_column_valid` | `i_column_ready`).
  - `o_fifo_rd` = {COUNT{pop}}, combinational.
  - On `pop`: load the column register from `i_fifo_rdata`, latch the counters into `o_xcoord`/`o_ycoord`, and set valid.
- On a handshake (`o_column_valid` & `i_column_ready`) with no pop in the same cycle, clear valid.
- Counters advance on `pop`:
  - x wraps at FRAME_WIDTH-1.
  - y increments on x wrap.
- Pop of the last column of a row (x = FRAME_WIDTH-1):
  - If y < FRAME_HEIGHT-1: go to GAP, or straight back to STREAM when LINE_GAP=0.
  - If y = FRAME_HEIGHT-1: go to DONE.
- GAP counts LINE_GAP cycles, then returns to STREAM. No pops occur in GAP. A pending output column may still hand off during GAP.
- DONE waits until the column register is drained, meaning valid=0 or a handshake happens this cycle. It then pulses `o_frame_done` for one cycle and returns to IDLE.
- Partial emptiness (any FIFO empty) stalls popping entirely. The FIFOs are never read unevenly.
- Downstream backpressure holds `o_column_data`, `o_xcoord` and `o_ycoord` stable while valid & !ready.
- `i_start` outside IDLE is ignored.
- Counter arithmetic is unsigned 16-bit. FRAME_WIDTH and FRAME_HEIGHT must be < 2^16; this is checked by an elaboration-time assertion.

## Timing
- Reset values: state IDLE, counters 0, `o_column_valid`=0, `o_column_data`=0, coords 0, `o_busy`=0, `o_frame_done`=0.
- Latency: FIFO head to `o_column_valid` is 1 cycle (registered stage).
- Throughput is one column per cycle when the FIFOs are non-empty and ready is held high; simultaneous pop and handshake keep valid=1.
- Row boundary: exactly LINE_GAP pop-free cycles after the last pop of a row.
- `o_frame_done` asserts in the cycle after the final column handshake. If the final column was already accepted, it asserts in the cycle after entering DONE.
- Reset asserted mid-frame clears everything immediately: the FSM returns to IDLE and the output column is discarded. The FIFOs are not flushed by this block.

## Structure
- Shared package `haar_pkg`: the FSM state enum, the `BYTE_WIDTH`/`BYTE_DOUBLE_WIDTH` constants, and a column-slice helper function.
- One natural sub-module, `column_pipe_reg`: a single-entry valid/ready register, with the data width parameterised to carry column plus coordinates.
- The FSM and counters stay in the top level.

## Test plan
- Reset, then `i_start`, with all FIFOs pre-filled and ready held at 1 (W=10, H=10, GAP=2):
  - 100 columns with x 0..9 and y 0..9.
  - A 2-cycle gap after each row.
  - `o_frame_done` one cycle after the last handshake.
- FIFO 3 empty for 5 cycles mid-row: no `o_fifo_rd` bit asserts during those cycles; the stream resumes at the same x with no duplicated or lost column.
- Ready held low for 4 cycles with valid high: data and coords are stable, the single pending column is not overwritten, and no pop occurs.
- LINE_GAP=0 with ready toggling 1,0,1,0: pops only when the register is free or being drained; total pops = 100.
- `reset_n` pulsed low at column (4,3): outputs go to reset values immediately, the next `i_start` restarts at (0,0), and `i_start` asserted during STREAM has no effect.
